pc_fetch_sequencer: RTL and testbench

//  Sequences the program-counter register: computes its next value every cycle
//  and runs the instruction-memory fetch handshake.
//  - Sits between the hazard/branch/exception logic, the PC register and instruction memory.
//  - Holds the PC during memory wait states and pipeline stalls.
//  - Applies redirects with fixed priority: exception > jump > branch.

---
 rtl/pc_fetch_sequencer_pkg.sv | 24 ++
 rtl/pc_fetch_sequencer_if.sv | 31 +++
 rtl/pc_fetch_sequencer_next_pc_mux.sv | 54 +++++
 rtl/pc_fetch_sequencer.sv | 119 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the PC fetch sequencer: FSM state encoding,
// redirect priority ranking, the sequential increment and the default vectors.
package pc_fetch_sequencer_pkg;

    localparam int unsigned PC_INCR              = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Numeric order is the redirect priority; a larger value wins.
    typedef enum logic [1:0] {
        PRIO_NONE   = 2'd0,
        PRIO_BRANCH = 2'd1,
        PRIO_JUMP   = 2'd2,
        PRIO_EXC    = 2'd3
    } prio_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer signal bundle: PC register link, instruction-memory handshake
// and the redirect/stall inputs from hazard, branch and exception logic.
interface pc_fetch_sequencer_if #(
    parameter int Address_width = 32
);
    logic [Address_width-1:0] PC_current;
    logic [Address_width-1:0] PC_next;
    logic                     Imem_req;
    logic [Address_width-1:0] Imem_addr;
    logic                     Imem_ready;
    logic                     Instr_valid;
    logic                     Stall;
    logic                     Branch_taken;
    logic [Address_width-1:0] Branch_target;
    logic                     Jump;
    logic [Address_width-1:0] Jump_target;
    logic                     Exception;
    logic                     Misalign_err;

    modport master (
        input  PC_current, Imem_ready, Stall, Branch_taken, Branch_target,
               Jump, Jump_target, Exception,
        output PC_next, Imem_req, Imem_addr, Instr_valid, Misalign_err
    );

    modport slave (
        output PC_current, Imem_ready, Stall, Branch_taken, Branch_target,
               Jump, Jump_target, Exception,
        input  PC_next, Imem_req, Imem_addr, Instr_valid, Misalign_err
    );
endinterface

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Combinational redirect arbitration: ranks this cycle's pulses, swaps misaligned
// targets for the exception vector, merges with the latched redirect, and increments.
module pc_fetch_sequencer_next_pc_mux
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                     Address_width = 32,
    parameter logic [Address_width-1:0] Exc_vector  = Address_width'(EXC_VECTOR_DEFAULT)
) (
    input  logic [Address_width-1:0] pc_i,
    input  logic                     exc_i,
    input  logic                     jump_i,
    input  logic [Address_width-1:0] jump_tgt_i,
    input  logic                     branch_i,
    input  logic [Address_width-1:0] branch_tgt_i,
    input  prio_e                    pend_prio_i,
    input  logic [Address_width-1:0] pend_addr_i,
    output prio_e                    cur_prio_o,
    output logic [Address_width-1:0] cur_addr_o,
    output logic                     cur_win_o,
    output logic                     cur_mis_o,
    output prio_e                    eff_prio_o,
    output logic [Address_width-1:0] eff_addr_o,
    output logic [Address_width-1:0] pc_incr_o
);

    logic [Address_width-1:0] raw_tgt;

    always_comb begin
        cur_prio_o = PRIO_NONE;
        raw_tgt    = '0;
        if (exc_i) begin
            cur_prio_o = PRIO_EXC;
            raw_tgt    = Exc_vector;
        end else if (jump_i) begin
            cur_prio_o = PRIO_JUMP;
            raw_tgt    = jump_tgt_i;
        end else if (branch_i) begin
            cur_prio_o = PRIO_BRANCH;
            raw_tgt    = branch_tgt_i;
        end

        cur_mis_o  = ((cur_prio_o == PRIO_JUMP) || (cur_prio_o == PRIO_BRANCH)) &&
                     (raw_tgt[1:0] != 2'b00);
        cur_addr_o = cur_mis_o ? Exc_vector : raw_tgt;

        // A fresh redirect of equal or higher rank replaces the latched one.
        cur_win_o  = (cur_prio_o != PRIO_NONE) && (cur_prio_o >= pend_prio_i);
        eff_prio_o = cur_win_o ? cur_prio_o : pend_prio_i;
        eff_addr_o = cur_win_o ? cur_addr_o : pend_addr_i;
    end

    assign pc_incr_o = pc_i + Address_width'(PC_INCR);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: drives the next PC every cycle and runs the
// instruction-memory request/ready handshake with stall and redirect handling.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                       Address_width = 32,
    parameter logic [Address_width-1:0] Reset_vector  = Address_width'(RESET_VECTOR_DEFAULT),
    parameter logic [Address_width-1:0] Exc_vector    = Address_width'(EXC_VECTOR_DEFAULT)
) (
    input  logic                 CLK,
    input  logic                 RST,
    pc_fetch_sequencer_if.master bus
);

    localparam int AW = Address_width;

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            vld_q, vld_d;
    logic            mis_q, mis_d;
    prio_e           pend_prio_q, pend_prio_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [AW-1:0]   pc_next;

    prio_e           cur_prio, eff_prio;
    logic [AW-1:0]   cur_addr, eff_addr, pc_incr;
    logic            cur_win, cur_mis;
    logic            resp, advance, squash;

    pc_fetch_sequencer_next_pc_mux #(
        .Address_width (AW),
        .Exc_vector    (Exc_vector)
    ) u_next_pc_mux (
        .pc_i         (bus.PC_current),
        .exc_i        (bus.Exception),
        .jump_i       (bus.Jump),
        .jump_tgt_i   (bus.Jump_target),
        .branch_i     (bus.Branch_taken),
        .branch_tgt_i (bus.Branch_target),
        .pend_prio_i  (pend_prio_q),
        .pend_addr_i  (pend_addr_q),
        .cur_prio_o   (cur_prio),
        .cur_addr_o   (cur_addr),
        .cur_win_o    (cur_win),
        .cur_mis_o    (cur_mis),
        .eff_prio_o   (eff_prio),
        .eff_addr_o   (eff_addr),
        .pc_incr_o    (pc_incr)
    );

    // An exception overrides a stall, both at a response and out of HOLD.
    always_comb begin
        resp    = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) && bus.Imem_ready;
        advance = (resp || (state_q == ST_HOLD)) && (!bus.Stall || (eff_prio == PRIO_EXC));
        squash  = advance && (eff_prio != PRIO_NONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_BOOT;
            req_q       <= 1'b0;
            vld_q       <= 1'b0;
            mis_q       <= 1'b0;
            pend_prio_q <= PRIO_NONE;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            vld_q       <= vld_d;
            mis_q       <= mis_d;
            pend_prio_q <= pend_prio_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:            state_d = ST_FETCH;
            ST_FETCH, ST_WAIT: begin
                if (advance)      state_d = ST_FETCH;
                else if (resp)    state_d = ST_HOLD;
                else              state_d = ST_WAIT;
            end
            ST_HOLD:            if (advance) state_d = ST_FETCH;
            default:            state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_next     = bus.PC_current;
        req_d       = (state_d == ST_FETCH) || (state_d == ST_WAIT);
        vld_d       = advance && !squash;
        mis_d       = cur_win && cur_mis;
        pend_prio_d = pend_prio_q;
        pend_addr_d = pend_addr_q;

        if (state_q == ST_BOOT) begin
            pc_next = Reset_vector;
        end else if (advance) begin
            pc_next = squash ? eff_addr : pc_incr;
        end

        // Consumed redirects clear; otherwise an accepted pulse is parked.
        if (advance) begin
            pend_prio_d = PRIO_NONE;
        end else if (cur_win) begin
            pend_prio_d = cur_prio;
            pend_addr_d = cur_addr;
        end
    end

    assign bus.PC_next      = pc_next;
    assign bus.Imem_req     = req_q;
    assign bus.Imem_addr    = bus.PC_current;
    assign bus.Instr_valid  = vld_q;
    assign bus.Misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: owns the PC register, drives directed and
// pseudo-random vectors, and checks every cycle against a behavioural model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0180;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    pc_fetch_sequencer_if #(.Address_width(32)) bus ();

    pc_fetch_sequencer #(
        .Address_width (32),
        .Reset_vector  (RV),
        .Exc_vector    (EV)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [31:0] pc_reg;
    always @(posedge CLK or negedge RST) begin
        if (!RST) pc_reg <= 32'h0;
        else      pc_reg <= bus.PC_next;
    end
    assign bus.PC_current = pc_reg;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: what the outputs must be this cycle, then what follows.
    bit          m_boot, m_req, m_hold, m_vld, m_mis;
    int          m_pend_rank;
    logic [31:0] m_pend_tgt, m_pc;

    always @(negedge CLK) begin : model
        int          cur_rank, eff_rank;
        logic [31:0] cur_tgt, eff_tgt, exp_next;
        bit          cur_mis, win, resp, adv;
        if (!RST) begin
            m_boot = 1; m_req = 0; m_hold = 0; m_vld = 0; m_mis = 0;
            m_pend_rank = 0; m_pend_tgt = 0; m_pc = RV;
            chk("rst_req", 32'(bus.Imem_req), 32'd0);
            chk("rst_valid", 32'(bus.Instr_valid), 32'd0);
            chk("rst_misalign", 32'(bus.Misalign_err), 32'd0);
        end else begin
            cur_rank = 0; cur_tgt = 0; cur_mis = 0; adv = 0;
            if (bus.Exception)         begin cur_rank = 3; cur_tgt = EV; end
            else if (bus.Jump)         begin cur_rank = 2; cur_tgt = bus.Jump_target; end
            else if (bus.Branch_taken) begin cur_rank = 1; cur_tgt = bus.Branch_target; end
            if ((cur_rank == 1 || cur_rank == 2) && cur_tgt[1:0] != 2'b00) begin
                cur_mis = 1; cur_tgt = EV;
            end
            win      = (cur_rank > 0) && (cur_rank >= m_pend_rank);
            eff_rank = win ? cur_rank : m_pend_rank;
            eff_tgt  = win ? cur_tgt  : m_pend_tgt;

            chk("m_addr", bus.Imem_addr, m_pc);
            chk("m_req", 32'(bus.Imem_req), 32'(m_req));
            chk("m_valid", 32'(bus.Instr_valid), 32'(m_vld));
            chk("m_misalign", 32'(bus.Misalign_err), 32'(m_mis));

            if (m_boot) begin
                exp_next = RV; m_boot = 0; m_req = 1;
            end else begin
                resp = m_req && bus.Imem_ready;
                adv  = (resp || m_hold) && (!bus.Stall || eff_rank == 3);
                if (adv) exp_next = (eff_rank != 0) ? eff_tgt : m_pc + 32'd4;
                else     exp_next = m_pc;
                if (adv)       begin m_req = 1; m_hold = 0; end
                else if (resp) begin m_req = 0; m_hold = 1; end
            end
            chk("m_pc_next", bus.PC_next, exp_next);

            m_vld = adv && (eff_rank == 0);
            m_mis = win && cur_mis;
            if (adv)      m_pend_rank = 0;
            else if (win) begin m_pend_rank = cur_rank; m_pend_tgt = cur_tgt; end
            m_pc = exp_next;
        end
    end

    task automatic cyc(input bit rdy, input bit st, input bit br, input logic [31:0] bt,
                       input bit jp, input logic [31:0] jt, input bit ex);
        @(posedge CLK); #1;
        bus.Imem_ready    = rdy;
        bus.Stall         = st;
        bus.Branch_taken  = br;
        bus.Branch_target = bt;
        bus.Jump          = jp;
        bus.Jump_target   = jt;
        bus.Exception     = ex;
        @(negedge CLK);
    endtask

    initial begin : stim
        logic [31:0] t;
        bus.Imem_ready = 0; bus.Stall = 0; bus.Branch_taken = 0; bus.Branch_target = 0;
        bus.Jump = 0; bus.Jump_target = 0; bus.Exception = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_req", 32'(bus.Imem_req), 32'd0);

        @(posedge CLK); #1; RST = 1; bus.Imem_ready = 1;
        @(negedge CLK);
        chk("boot_next", bus.PC_next, 32'h0);
        chk("boot_valid", 32'(bus.Instr_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_next4", bus.PC_next, 32'h4);
        chk("seq_valid_c2", 32'(bus.Instr_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_next8", bus.PC_next, 32'h8);
        chk("seq_valid_c3", 32'(bus.Instr_valid), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("seq_next12", bus.PC_next, 32'hC);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Memory wait states at 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("wait_req", 32'(bus.Imem_req), 32'd1);
            chk("wait_addr", bus.Imem_addr, 32'h10);
            chk("wait_next", bus.PC_next, 32'h10);
        end
        cyc(1, 0, 0, 0, 0, 0, 0); chk("wait_done_next", bus.PC_next, 32'h14);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("wait_done_valid", 32'(bus.Instr_valid), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // Branch during WAIT at 0x20.
        cyc(0, 0, 0, 0, 0, 0, 0); chk("br_wait_addr", bus.Imem_addr, 32'h20);
        cyc(0, 0, 1, 32'h40, 0, 0, 0); chk("br_latched_next", bus.PC_next, 32'h20);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("br_redirect_next", bus.PC_next, 32'h40);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("br_squash_valid", 32'(bus.Instr_valid), 32'd0);
        // Jump beats branch in the same cycle.
        cyc(1, 0, 1, 32'h40, 1, 32'h80, 0); chk("jmp_prio_next", bus.PC_next, 32'h80);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("jmp_squash_valid", 32'(bus.Instr_valid), 32'd0);
        // Stall for four cycles after an accept.
        cyc(1, 1, 0, 0, 0, 0, 0); chk("stall_accept_next", bus.PC_next, 32'h84);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            chk("stall_req", 32'(bus.Imem_req), 32'd0);
            chk("stall_next", bus.PC_next, 32'h84);
        end
        cyc(1, 0, 0, 0, 0, 0, 0); chk("unstall_next", bus.PC_next, 32'h88);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("unstall_valid", 32'(bus.Instr_valid), 32'd1);
        // Exception during the second stalled cycle.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0); chk("exc_hold_next", bus.PC_next, 32'h8C);
        cyc(1, 1, 0, 0, 0, 0, 1); chk("exc_next", bus.PC_next, EV);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("exc_misalign", 32'(bus.Misalign_err), 32'd0);
        chk("exc_valid", 32'(bus.Instr_valid), 32'd0);
        // Misaligned branch target.
        cyc(1, 0, 1, 32'h42, 0, 0, 0); chk("mis_next", bus.PC_next, EV);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("mis_pulse", 32'(bus.Misalign_err), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("mis_pulse_end", 32'(bus.Misalign_err), 32'd0);
        // Wrap-around of the incrementer.
        cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0); chk("wrap_jump", bus.PC_next, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("wrap_next", bus.PC_next, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("wrap_after", bus.PC_next, 32'h4);
        // Reset in the middle of a memory wait.
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK); #1; RST = 0; bus.Imem_ready = 1;
        @(negedge CLK); chk("midrst_valid", 32'(bus.Instr_valid), 32'd0);
        @(posedge CLK); #1; RST = 1;
        @(negedge CLK); chk("midrst_boot_next", bus.PC_next, RV);
        chk("midrst_boot_valid", 32'(bus.Instr_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("midrst_valid2", 32'(bus.Instr_valid), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0); chk("midrst_resume", bus.PC_next, 32'h8);
        // Mixed traffic, checked by the model alone.
        for (int i = 0; i < 200; i++) begin
            t = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 5) == 0) t = t | 32'h1;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, t,
                $urandom_range(0, 9) == 0, t + 32'h100,
                $urandom_range(0, 19) == 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
